// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It owns the
//   HI/LO result pair and processes one bit per clock over WIDTH clocks.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while busy=0
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         multiplicand/dividend (rs), multiplier/divisor (rt)
//   busy         operation in flight (start ignored)
//   done         one-cycle pulse, hi/lo valid in this cycle
//   div_by_zero  set on completion of a DIV/DIVU with b==0
//   hi, lo       MULT: upper/lower product; DIV: remainder/quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic             is_div;
  logic             neg_hi;     // negate the high half (mult: whole product)
  logic             neg_lo;     // negate the quotient
  logic             dbz_pend;   // current op is a divide by zero
  logic [WIDTH-1:0] acc;        // mult: upper partial product; div: remainder
  logic [WIDTH-1:0] mq;         // mult: multiplier/low product; div: dividend/quotient
  logic [WIDTH-1:0] mcand;      // |b|
  logic [CW-1:0]    count;

  // Operand magnitudes; unsigned ops pass straight through.
  logic             signed_op;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // One shift-add multiply step: add, then shift {carry,acc,mq} right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc} + {1'b0, mcand};

  // One restoring divide step. The shifted remainder needs WIDTH+1 bits;
  // when it is >= divisor the difference is < divisor, so WIDTH bits of
  // the subtraction are exact.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  assign div_shift = {acc, mq[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand});
  assign div_diff  = div_shift[WIDTH-1:0] - mcand;

  // Sign fix-up of the finished result.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign prod_fix = neg_hi ? -{acc, mq} : {acc, mq};

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (dbz_pend) begin
      fix_hi = acc;                 // holds the raw dividend
      fix_lo = {WIDTH{1'b1}};
    end else if (is_div) begin
      fix_hi = neg_hi ? -acc : acc;
      fix_lo = neg_lo ? -mq  : mq;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_div      <= 1'b0;
      neg_hi      <= 1'b0;
      neg_lo      <= 1'b0;
      dbz_pend    <= 1'b0;
      acc         <= '0;
      mq          <= '0;
      mcand       <= '0;
      count       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            mq     <= mag_a;
            mcand  <= mag_b;
            acc    <= '0;
            count  <= CW'(WIDTH);
            if (op[1]) begin
              neg_lo <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi <= signed_op & a[WIDTH-1];
            end else begin
              neg_lo <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            end
            if (op[1] && (b == '0)) begin
              dbz_pend <= 1'b1;
              acc      <= a;
              state    <= FIN;
            end else begin
              dbz_pend <= 1'b0;
              state    <= RUN;
            end
          end
        end

        RUN: begin
          if (is_div) begin
            if (div_ge) begin
              acc <= div_diff;
              mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_shift[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b0};
            end
          end else if (mq[0]) begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[WIDTH-1:1]};
            mq  <= {acc[0], mq[WIDTH-1:1]};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= FIN;
          end
        end

        FIN: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          div_by_zero <= dbz_pend;
          done        <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Randomized and directed stimulus for mult_div_unit, checked against a
//   plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks_total  = 0;
  int checks_passed = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  task automatic ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
    longint sx, sy, q, r, p;
    longint unsigned up;
    rz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        p = sx * sy;
        rh = p[63:32];
        rl = p[31:0];
      end
      2'b01: begin
        up = {32'b0, x} * {32'b0, y};
        rh = up[63:32];
        rl = up[31:0];
      end
      default: begin
        if (y == 0) begin
          rh = x;
          rl = '1;
          rz = 1'b1;
        end else if (o == 2'b10) begin
          q  = sx / sy;
          r  = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
    endcase
  endtask

  // Issue one op at the current negedge and follow it to done. Leaves the
  // caller at the negedge where done is visible, so a following call starts
  // in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit noise);
    logic [W-1:0] eh, el;
    logic         ez;
    int           edges;
    int           busy_cycles;
    ref_op(o, x, y, eh, el, ez);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cycles++;
      if (noise) begin
        start = 1'($urandom);
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0b edges=%0d busy=%0d",
             o, x, y, hi, lo, div_by_zero, edges, busy_cycles);
    check("done_seen", 64'(done), 64'(1));
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("dbz", 64'(div_by_zero), 64'(ez));
    // Normal ops take WIDTH+1 edges and stay busy for WIDTH+1 cycles;
    // divide by zero takes one of each.
    check("latency", 64'(edges), (o[1] && y == 0) ? 64'(1) : 64'(W + 1));
    check("busy_cycles", 64'(busy_cycles), (o[1] && y == 0) ? 64'(1) : 64'(W + 1));
  endtask

  logic [1:0]   d_op [10] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
  logic [W-1:0] d_a  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100,
                              32'h80000000, 32'd5, 32'd9, 32'h7, 32'h7FFFFFFF};
  logic [W-1:0] d_b  [10] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'd7,
                              32'hFFFFFFFF, 32'd0, 32'd3, 32'hFFFFFFFE, 32'h80000000};

  initial begin
    logic [W-1:0] hold_hi, hold_lo;
    logic [W-1:0] ra, rb;
    bit           saw_done;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, back to back (each start lands in the previous done cycle).
    for (int i = 0; i < 10; i++) run_op(d_op[i], d_a[i], d_b[i], 1'b0);

    // Result holds after completion with no further start.
    hold_hi = hi; hold_lo = lo;
    repeat (3) @(negedge clk);
    check("hold_done", 64'(done), 64'(0));
    check("hold_hi", 64'(hi), 64'(hold_hi));
    check("hold_lo", 64'(lo), 64'(hold_lo));

    // Noise while busy must not disturb the result.
    run_op(2'd1, 32'd12345, 32'd678, 1'b1);
    run_op(2'd2, 32'hFFFF0000, 32'd3, 1'b1);

    // Randomized ops, some with zero divisors and busy-time noise.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op(2'($urandom), ra, rb, 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Reset at iteration 10 of a multiply aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'hDEADBEEF; b = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'(0));
    $display("reset abort: busy=%0b hi=%08h lo=%08h", busy, hi, lo);
    run_op(2'd1, 32'd6, 32'd7, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
